op_select_sequencer: RTL and testbench

- Control stage directly upstream of the team's 8:1 operation-select mux.
- Accepts a 3-bit opcode over a valid/ready handshake and drives the mux select lines s2..s0.
- Steps a bit index through an N-bit word so surrounding logic can present bit i of each operation result to the mux inputs. After each settle interval it samples the 1-bit mux output and assembles the N-bit result, which it presents on a valid/ready output.

---
 rtl/op_select_sequencer_if.sv | 29 ++
 rtl/op_select_sequencer.sv | 110 +++++++++++
 tb/tb_op_select_sequencer.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/op_select_sequencer_if.sv
// Handshake and mux-control bundle between the op-select sequencer and its neighbours.
// The slave view is the sequencer; the master view is the command source plus the mux path.
interface op_select_sequencer_if #(
   parameter int N    = 4,
   parameter int IDXW = 2
);
   logic            cmd_valid;
   logic            cmd_ready;
   logic [2:0]      cmd_op;
   logic            s0;
   logic            s1;
   logic            s2;
   logic [IDXW-1:0] bit_idx;
   logic            mux_f;
   logic            res_valid;
   logic            res_ready;
   logic [N-1:0]    res_data;
   logic            busy;

   modport slave (
      input  cmd_valid, cmd_op, mux_f, res_ready,
      output cmd_ready, s0, s1, s2, bit_idx, res_valid, res_data, busy
   );

   modport master (
      output cmd_valid, cmd_op, mux_f, res_ready,
      input  cmd_ready, s0, s1, s2, bit_idx, res_valid, res_data, busy
   );
endinterface

// File: rtl/op_select_sequencer.sv
// Drives the 8:1 op-select mux, walks bit_idx across the word, samples mux_f after each
// settle interval and hands the assembled word out over a valid/ready port.
module op_select_sequencer #(
   parameter int N      = 4,
   parameter int IDXW   = 2,
   parameter int SETTLE = 1
) (
   input logic                  clk,
   input logic                  reset,
   op_select_sequencer_if.slave bus
);
   localparam int              CW       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'((SETTLE > 0) ? SETTLE - 1 : 0);
   localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_SAMPLE, ST_DONE} state_e;

   state_e          state_q, state_d;
   logic [2:0]      sel_q, sel_d;
   logic [IDXW-1:0] idx_q, idx_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    res_q, res_d;
   logic            cmd_ready;
   logic            busy;
   logic            res_valid;

   // NOTE: registers update with <= so every flop samples the pre-edge value of its peers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: each always_comb output gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (bus.cmd_valid) state_d = (SETTLE == 0) ? ST_SAMPLE : ST_SETTLE;
         ST_SETTLE: if (cnt_q == CNT_LAST) state_d = ST_SAMPLE;
         ST_SAMPLE: begin
            if (idx_q == IDX_LAST)  state_d = ST_DONE;
            else if (SETTLE == 0)   state_d = ST_SAMPLE;
            else                    state_d = ST_SETTLE;
         end
         ST_DONE:   if (bus.res_ready) state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b0;
      res_valid = 1'b0;
      case (state_q)
         ST_IDLE:              cmd_ready = 1'b1;
         ST_SETTLE, ST_SAMPLE: busy      = 1'b1;
         ST_DONE:              res_valid = 1'b1;
         default:              cmd_ready = 1'b0;
      endcase
   end

   // Select lines and the partial word only move on accept and during SAMPLE.
   always_comb begin
      sel_d = sel_q;
      idx_d = idx_q;
      cnt_d = cnt_q;
      res_d = res_q;
      case (state_q)
         ST_IDLE: begin
            if (bus.cmd_valid) begin
               sel_d = bus.cmd_op;
               idx_d = '0;
               cnt_d = '0;
               res_d = '0;
            end
         end
         ST_SETTLE: cnt_d = cnt_q + CW'(1);
         ST_SAMPLE: begin
            res_d[idx_q] = bus.mux_f;
            if (idx_q != IDX_LAST) begin
               idx_d = idx_q + IDXW'(1);
               cnt_d = '0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q <= '0;
         idx_q <= '0;
         cnt_q <= '0;
         res_q <= '0;
      end else begin
         sel_q <= sel_d;
         idx_q <= idx_d;
         cnt_q <= cnt_d;
         res_q <= res_d;
      end
   end

   assign bus.cmd_ready = cmd_ready;
   assign bus.busy      = busy;
   assign bus.res_valid = res_valid;
   assign bus.s2        = sel_q[2];
   assign bus.s1        = sel_q[1];
   assign bus.s0        = sel_q[0];
   assign bus.bit_idx   = idx_q;
   assign bus.res_data  = res_q;
endmodule

// File: tb/tb_op_select_sequencer.sv
// Bench for op_select_sequencer: one default build and one SETTLE=0 build, driven one at a
// time; the expected word for each accepted opcode is the mux_f pattern the bench presents.
module tb_op_select_sequencer;
   localparam int N     = 4;
   localparam int IDXW  = 2;
   localparam int SET_A = 1;
   localparam int SET_B = 0;

   typedef struct {
      int           which;
      logic [2:0]   op;
      logic [N-1:0] pat;
      int           t;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]      rst, cv, rr;
   logic [2:0]      op_r [2];
   logic [N-1:0]    pat  [2];
   logic [1:0]      rv, crdy, bsy;
   logic [2:0]      sel  [2];
   logic [IDXW-1:0] bidx [2];
   logic [N-1:0]    rd   [2];

   exp_t sb[$];
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_pass = 0;

   always @(posedge clk) cyc <= cyc + 1;

   op_select_sequencer_if #(.N(N), .IDXW(IDXW)) ifa ();
   op_select_sequencer_if #(.N(N), .IDXW(IDXW)) ifb ();

   op_select_sequencer #(.N(N), .IDXW(IDXW), .SETTLE(SET_A)) dut_a (
      .clk(clk), .reset(rst[0]), .bus(ifa)
   );
   op_select_sequencer #(.N(N), .IDXW(IDXW), .SETTLE(SET_B)) dut_b (
      .clk(clk), .reset(rst[1]), .bus(ifb)
   );

   // The mux path: bit bit_idx of the current operand pattern appears on mux_f.
   assign ifa.cmd_valid = cv[0];
   assign ifa.cmd_op    = op_r[0];
   assign ifa.res_ready = rr[0];
   assign ifa.mux_f     = pat[0][ifa.bit_idx];
   assign ifb.cmd_valid = cv[1];
   assign ifb.cmd_op    = op_r[1];
   assign ifb.res_ready = rr[1];
   assign ifb.mux_f     = pat[1][ifb.bit_idx];

   assign rv[0]   = ifa.res_valid;
   assign crdy[0] = ifa.cmd_ready;
   assign bsy[0]  = ifa.busy;
   assign sel[0]  = {ifa.s2, ifa.s1, ifa.s0};
   assign bidx[0] = ifa.bit_idx;
   assign rd[0]   = ifa.res_data;
   assign rv[1]   = ifb.res_valid;
   assign crdy[1] = ifb.cmd_ready;
   assign bsy[1]  = ifb.busy;
   assign sel[1]  = {ifb.s2, ifb.s1, ifb.s0};
   assign bidx[1] = ifb.bit_idx;
   assign rd[1]   = ifb.res_data;

   function automatic int lat(input int i);
      return N * (((i == 0) ? SET_A : SET_B) + 1);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic push(input int i, input logic [2:0] o, input logic [N-1:0] p);
      exp_t e;
      e.which = i;
      e.op    = o;
      e.pat   = p;
      e.t     = cyc;
      sb.push_back(e);
   endtask

   task automatic wait_ready(input int i);
      int k;
      k = 0;
      @(negedge clk);
      while (!crdy[i] && k < 100) begin
         @(negedge clk);
         k++;
      end
      if (!crdy[i]) check("cmd_ready_timeout", crdy[i], 1);
   endtask

   task automatic accept(input int i, input logic [2:0] o, input logic [N-1:0] p);
      wait_ready(i);
      op_r[i] = o;
      pat[i]  = p;
      cv[i]   = 1'b1;
      @(posedge clk);
      #1;
      push(i, o, p);
      cv[i] = 1'b0;
      check("sel_after_accept", sel[i], o);
      check("busy_after_accept", bsy[i], 1);
   endtask

   task automatic finish_word(input int i, input int hold, input bit noise);
      int k;
      k = 0;
      @(negedge clk);
      while (!rv[i] && k < 100) begin
         rr[i] = noise ? 1'($urandom % 2) : 1'b0;
         @(negedge clk);
         k++;
      end
      if (!rv[i]) check("res_valid_timeout", rv[i], 1);
      rr[i] = 1'b0;
      repeat (hold) @(negedge clk);
      rr[i] = 1'b1;
      @(posedge clk);
      #1;
      rr[i] = 1'b0;
      check("ready_after_consume", crdy[i], 1);
      check("valid_after_consume", rv[i], 0);
   endtask

   // Monitor: pops one expectation per result and checks the word stays put while held.
   initial begin
      bit   prv [2];
      exp_t cur [2];
      exp_t e;
      prv[0] = 1'b0;
      prv[1] = 1'b0;
      forever begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (rst[i]) begin
               prv[i] = 1'b0;
            end else if (rv[i] && !prv[i]) begin
               if (sb.size() == 0) begin
                  check("unexpected_result", rv[i], 0);
               end else begin
                  e      = sb.pop_front();
                  cur[i] = e;
                  check("result_instance", i, e.which);
                  check("res_data", rd[i], e.pat);
                  check("select_at_result", sel[i], e.op);
                  check("latency", cyc - e.t, lat(i));
               end
               prv[i] = rv[i];
            end else if (rv[i] && prv[i]) begin
               check("held_res_data", rd[i], cur[i].pat);
               check("held_cmd_ready", crdy[i], 0);
               check("held_busy", bsy[i], 0);
            end else begin
               prv[i] = rv[i];
            end
         end
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_chk);
      $fatal(1);
   end

   initial begin
      logic [N-1:0] pats [8];
      logic [2:0]   o;
      logic [N-1:0] p;
      int           k;
      pats[0] = 4'h0; pats[1] = 4'hF; pats[2] = 4'h5; pats[3] = 4'hA;
      pats[4] = 4'h3; pats[5] = 4'hC; pats[6] = 4'h9; pats[7] = 4'h6;
      rst = 2'b11; cv = 2'b00; rr = 2'b00;
      op_r[0] = '0; op_r[1] = '0; pat[0] = '0; pat[1] = '0;
      repeat (3) @(negedge clk);
      rst = 2'b00;
      #1;
      for (int i = 0; i < 2; i++) begin
         check("reset_cmd_ready", crdy[i], 1);
         check("reset_res_valid", rv[i], 0);
         check("reset_busy", bsy[i], 0);
         check("reset_select", sel[i], 0);
         check("reset_bit_idx", bidx[i], 0);
         check("reset_res_data", rd[i], 0);
      end

      // Basic op with backpressure; cmd_valid stays high carrying the next opcode.
      wait_ready(0);
      op_r[0] = 3'b101; pat[0] = 4'b1010; cv[0] = 1'b1;
      @(posedge clk);
      #1;
      push(0, 3'b101, 4'b1010);
      check("basic_select", sel[0], 3'b101);
      op_r[0] = 3'b011;
      for (int j = 0; j < N * (SET_A + 1); j++) begin
         check("bit_idx_trace_a", bidx[0], j / (SET_A + 1));
         @(posedge clk);
         #1;
      end
      check("basic_res_valid", rv[0], 1);
      check("basic_bit_idx_done", bidx[0], N - 1);
      repeat (5) begin
         @(posedge clk);
         #1;
         check("bp_res_valid", rv[0], 1);
         check("bp_res_data", rd[0], 4'b1010);
         check("bp_cmd_ready", crdy[0], 0);
         check("bp_busy", bsy[0], 0);
         check("bp_select", sel[0], 3'b101);
      end
      rr[0] = 1'b1;
      @(posedge clk);
      #1;
      rr[0] = 1'b0;
      check("bp_idle_ready", crdy[0], 1);
      check("bp_idle_valid", rv[0], 0);
      pat[0] = 4'b1100;
      @(posedge clk);
      #1;
      push(0, 3'b011, 4'b1100);
      cv[0] = 1'b0;
      check("bp_next_accept_busy", bsy[0], 1);
      check("bp_next_select", sel[0], 3'b011);
      finish_word(0, 0, 1'b0);

      for (int i = 0; i < 8; i++) begin
         accept(0, 3'(i), pats[i]);
         finish_word(0, $urandom % 3, 1'b1);
      end

      // Opcode changes and cmd_valid toggling mid-word must not disturb the latched select.
      accept(0, 3'b001, 4'b0101);
      repeat (6) begin
         @(negedge clk);
         cv[0]   = ~cv[0];
         op_r[0] = 3'b110;
         #1;
         check("sel_held_mid_word", sel[0], 3'b001);
         check("no_accept_mid_word", crdy[0], 0);
      end
      cv[0] = 1'b0;
      finish_word(0, 1, 1'b0);

      // Asynchronous reset part-way through a word.
      accept(0, 3'b111, 4'b1111);
      k = 0;
      @(negedge clk);
      while (bidx[0] != 2 && k < 20) begin
         @(negedge clk);
         k++;
      end
      check("reached_bit_idx_2", bidx[0], 2);
      #2;
      rst[0] = 1'b1;
      #1;
      sb.delete();
      check("async_rst_res_valid", rv[0], 0);
      check("async_rst_select", sel[0], 0);
      check("async_rst_bit_idx", bidx[0], 0);
      check("async_rst_busy", bsy[0], 0);
      check("async_rst_res_data", rd[0], 0);
      @(posedge clk);
      @(negedge clk);
      rst[0] = 1'b0;
      #1;
      check("post_rst_cmd_ready", crdy[0], 1);
      repeat (5) @(negedge clk);
      check("idle_stays_ready", crdy[0], 1);
      check("idle_stays_not_busy", bsy[0], 0);
      check("idle_no_result", rv[0], 0);

      repeat (20) begin
         o = 3'($urandom);
         p = N'($urandom);
         accept(0, o, p);
         finish_word(0, $urandom % 4, 1'b1);
      end

      // SETTLE=0 build: one sample per cycle.
      wait_ready(1);
      op_r[1] = 3'b011; pat[1] = 4'b0110; cv[1] = 1'b1;
      @(posedge clk);
      #1;
      push(1, 3'b011, 4'b0110);
      cv[1] = 1'b0;
      check("b_select", sel[1], 3'b011);
      for (int j = 0; j < N * (SET_B + 1); j++) begin
         check("bit_idx_trace_b", bidx[1], j / (SET_B + 1));
         @(posedge clk);
         #1;
      end
      check("b_res_valid", rv[1], 1);
      finish_word(1, 2, 1'b0);

      repeat (10) begin
         o = 3'($urandom);
         p = N'($urandom);
         accept(1, o, p);
         finish_word(1, $urandom % 3, 1'b1);
      end

      repeat (3) @(negedge clk);
      check("scoreboard_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
